// File: rtl/diff_freq_serial_in_pkg.sv
// Shared definitions for the dual-frequency serial link (receiver and transmitter).
package diff_freq_serial_in_pkg;

   // FSM state encoding shared by both ends of the link
   typedef enum logic {
      S_IDLE = 1'b0,
      S_DATA = 1'b1
   } state_t;

   // Default ticks per bit and its mid-point
   localparam int TICK_PER_BIT_DEF = 16;
   localparam int MID_TICK_DEF     = TICK_PER_BIT_DEF / 2;

   // Mid-bit tick index for a given oversampling ratio
   function automatic int mid_tick(input int tick_per_bit);
      return tick_per_bit / 2;
   endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter; max_tick is high for one clock every M clocks.
module mod_m_counter #(
   parameter int M = 10
) (
   input  logic clk,
   input  logic rst_n,
   output logic max_tick
);

   localparam int N = (M > 1) ? $clog2(M) : 1;

   logic [N-1:0] cnt;

   // Wrap to zero after M-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (cnt == N'(M - 1)) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
   end

   assign max_tick = (cnt == N'(M - 1));

endmodule

// File: rtl/diff_freq_serial_in.sv
// Dual-frequency serial receiver: 2-flop synchronizer, selectable 10/20 kHz tick,
// mid-bit sampling, LSB-first deserialization into DATA_BIT-wide words.
// Optional build macro SERIAL_IN_MAJORITY_VOTE_EN: 2-of-3 vote over the ticks
// around mid-bit instead of a single sample.
module diff_freq_serial_in
   import diff_freq_serial_in_pkg::*;
#(
   parameter int DATA_BIT     = 16,
   parameter int TICK_PER_BIT = 16,
   parameter int TICK_10K_HZ  = 63,
   parameter int TICK_20K_HZ  = 31
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_sel_freq,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_repeat,
   input  logic                i_serial,
   output logic [DATA_BIT-1:0] o_data,
   output logic                o_busy,
   output logic                o_done_tick
);

   localparam int TW  = $clog2(TICK_PER_BIT);
   localparam int BW  = $clog2(DATA_BIT);
   localparam int MID = mid_tick(TICK_PER_BIT);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BIT - 1);

   state_t                state;
   logic [TW-1:0]         tick_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_BIT-1:0]   shreg;
   logic [DATA_BIT-1:0]   shreg_nxt;
   logic                  sync1, sync2;
   logic                  tick, tick_10k, tick_20k;
   logic                  data_tick;
   logic                  shift_en;
   logic                  new_bit;

   mod_m_counter #(.M(TICK_10K_HZ)) u_tick_10k (.clk(clk), .rst_n(rst_n), .max_tick(tick_10k));
   mod_m_counter #(.M(TICK_20K_HZ)) u_tick_20k (.clk(clk), .rst_n(rst_n), .max_tick(tick_20k));

   assign tick      = i_sel_freq ? tick_20k : tick_10k;
   assign data_tick = (state == S_DATA) && tick && !i_stop;

   // Bring the asynchronous line into the clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= i_serial;
         sync2 <= sync1;
      end
   end

`ifdef SERIAL_IN_MAJORITY_VOTE_EN
   logic vote0, vote1;

   // Capture the two early votes; the third is the live sample at the shift tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote0 <= 1'b0;
         vote1 <= 1'b0;
      end else if (data_tick) begin
         if (tick_cnt == TW'(MID - 1)) vote0 <= sync2;
         if (tick_cnt == TW'(MID))     vote1 <= sync2;
      end
   end

   assign shift_en = data_tick && (tick_cnt == TW'(MID + 1));
   assign new_bit  = (vote0 & vote1) | (vote0 & sync2) | (vote1 & sync2);
`else
   assign shift_en = data_tick && (tick_cnt == TW'(MID));
   assign new_bit  = sync2;
`endif

   // New bit enters at the MSB so the first (LSB) bit ends at bit 0.
   // Using the shifted value lets the last sample and word load share a tick.
   assign shreg_nxt = shift_en ? {new_bit, shreg[DATA_BIT-1:1]} : shreg;

   // Main FSM with counters, shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         o_data      <= '0;
         o_busy      <= 1'b0;
         o_done_tick <= 1'b0;
      end else begin
         o_done_tick <= 1'b0;
         shreg       <= shreg_nxt;
         if (i_stop) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_start) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= S_DATA;
                     o_busy   <= 1'b1;
                  end
               end
               S_DATA: begin
                  if (tick) begin
                     if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                           o_data      <= shreg_nxt;
                           o_done_tick <= 1'b1;
                           bit_cnt     <= '0;
                           if (!i_repeat) begin
                              state  <= S_IDLE;
                              o_busy <= 1'b0;
                           end
                        end else begin
                           bit_cnt <= bit_cnt + 1'b1;
                        end
                     end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Directed bench for diff_freq_serial_in with a word scoreboard.
module tb_diff_freq_serial_in;

   localparam int M10 = 63;
   localparam int M20 = 31;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_sel_freq, i_start, i_stop, i_repeat, i_serial;
   logic [15:0] o_data;
   logic        o_busy, o_done_tick;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc;

   logic [15:0] exp_q[$];
   logic [15:0] obs_d[$];
   int          obs_t[$];

   diff_freq_serial_in dut (
      .clk(clk), .rst_n(rst_n), .i_sel_freq(i_sel_freq), .i_start(i_start),
      .i_stop(i_stop), .i_repeat(i_repeat), .i_serial(i_serial),
      .o_data(o_data), .o_busy(o_busy), .o_done_tick(o_done_tick)
   );

   always #5 clk = ~clk;

   // Posedges since reset release; the DUT tick dividers restart with it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Record every completed word and when it appeared
   always @(negedge clk) begin
      if (o_done_tick) begin
         obs_d.push_back(o_data);
         obs_t.push_back(cyc);
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic tick_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Park so that a start raised now sees its first tick one clock after arming
   task automatic align(input int m);
      int g = 0;
      do begin
         tick_wait(1);
         g++;
      end while ((cyc % m) != m - 2 && g < 200);
      if (g >= 200) chk("align_timeout", 0, 1);
   endtask

   task automatic drive_bits(input logic [15:0] w, input int m, input int nbits, input bit arm);
      for (int k = 0; k < nbits; k++) begin
         i_serial = w[k];
         if (k == 0 && arm) begin
            i_start = 1'b1;
            tick_wait(1);
            i_start = 1'b0;
            chk("busy_rise", o_busy, 1);
            tick_wait(16 * m - 1);
         end else begin
            tick_wait(16 * m);
         end
      end
   endtask

   task automatic expect_word(input string tag, output int t);
      int g = 0;
      t = -1;
      while (obs_d.size() == 0 && g < 20000) begin
         tick_wait(1);
         g++;
      end
      if (obs_d.size() == 0 || exp_q.size() == 0) begin
         chk({tag, "_missing"}, 0, 1);
      end else begin
         t = obs_t.pop_front();
         chk(tag, obs_d.pop_front(), exp_q.pop_front());
      end
   endtask

   initial begin
      int n0, t1, t2;
      logic [15:0] gl_exp;
      rst_n = 1'b0; i_sel_freq = 1'b0; i_start = 1'b0; i_stop = 1'b0;
      i_repeat = 1'b0; i_serial = 1'b0;
      tick_wait(3);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done_tick, 0);
      rst_n = 1'b1;

      // Single word at 10 kHz
      align(M10);
      exp_q.push_back(16'hA5C3);
      drive_bits(16'hA5C3, M10, 16, 1);
      expect_word("w_a5c3", t1);
      chk("a5c3_single_pulse", obs_d.size(), 0);
      chk("a5c3_busy_after", o_busy, 0);

      // Single word at 20 kHz, exact done latency
      i_sel_freq = 1'b1;
      align(M20);
      n0 = cyc;
      exp_q.push_back(16'h0001);
      drive_bits(16'h0001, M20, 16, 1);
      expect_word("w_0001", t1);
      chk("latency_20k", t1 - n0, 2 + M20 * 255);

      // Back-to-back words in repeat mode
      i_repeat = 1'b1;
      align(M20);
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'hFFFF);
      drive_bits(16'h1234, M20, 16, 1);
      drive_bits(16'hFFFF, M20, 16, 0);
      chk("rep_busy_high", o_busy, 1);
      expect_word("w_1234", t1);
      expect_word("w_ffff", t2);
      chk("rep_interval", t2 - t1, 16 * 16 * M20);
      i_stop = 1'b1;
      tick_wait(1);
      i_stop = 1'b0;
      i_repeat = 1'b0;
      chk("rep_stop_busy", o_busy, 0);

      // Abort during bit 7
      align(M20);
      drive_bits(16'hC0DE, M20, 7, 1);
      i_serial = 1'b0;
      tick_wait(8 * M20);
      i_stop = 1'b1;
      tick_wait(1);
      i_stop = 1'b0;
      chk("stop_busy", o_busy, 0);
      chk("stop_data_held", o_data, 16'hFFFF);
      tick_wait(16 * 16 * M20);
      chk("stop_no_done", obs_d.size(), 0);

      // Capture after an abort
      align(M20);
      exp_q.push_back(16'h5A5A);
      drive_bits(16'h5A5A, M20, 16, 1);
      expect_word("w_5a5a", t1);

      // Simultaneous start and stop: stays idle
      i_start = 1'b1; i_stop = 1'b1;
      tick_wait(3);
      chk("startstop_busy", o_busy, 0);
      i_start = 1'b0; i_stop = 1'b0;
      tick_wait(2);
      chk("startstop_busy_after", o_busy, 0);

      // Reset mid-word
      align(M20);
      drive_bits(16'hBEEF, M20, 5, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_data", o_data, 0);
      chk("midrst_busy", o_busy, 0);
      chk("midrst_done", o_done_tick, 0);
      i_serial = 1'b0;
      tick_wait(3);
      rst_n = 1'b1;

      // One-tick glitch centred on the bit-3 sample
`ifdef SERIAL_IN_MAJORITY_VOTE_EN
      gl_exp = 16'h0F0F;
`else
      gl_exp = 16'h0F07;
`endif
      align(M20);
      exp_q.push_back(gl_exp);
      fork
         drive_bits(16'h0F0F, M20, 16, 1);
         begin
            tick_wait(M20 * 56 - 15);
            i_serial = ~i_serial;
            tick_wait(M20);
            i_serial = ~i_serial;
         end
      join
      expect_word("w_glitch", t1);
      chk("scoreboard_empty", exp_q.size() + obs_d.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
